// File: rtl/bomber_pkg.sv
// Shared definitions for the slave-board keypad command path.
//   - key bit positions inside the 5-bit key field
//   - fixed upper marker of every command byte
//   - command-byte layout and a helper that assembles one
//   - transmitter FSM state encoding (visible for checkers and debug)
package bomber_pkg;

  localparam int UP       = 0;
  localparam int DOWN     = 1;
  localparam int LEFT     = 2;
  localparam int RIGHT    = 3;
  localparam int ACTION   = 4;
  localparam int NUM_KEYS = 5;

  localparam logic [2:0] CMD_MARKER = 3'b101;

  typedef struct packed {
    logic [2:0] marker;
    logic [4:0] keys;
  } cmd_byte_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic cmd_byte_t make_cmd(input logic [4:0] keys);
    cmd_byte_t c;
    c.marker = CMD_MARKER;
    c.keys   = keys;
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit,
// each CLKS_PER_BIT clock cycles long.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   data[7:0]    byte to send, sampled when accepted
//   valid        a byte is offered on data
//   ready        transmitter can accept a byte this cycle
//   tx           serial line, idle high, registered
// Handshake: a byte is transferred on a rising clk edge where valid and
// ready are both high; ready is high exactly while the FSM is in TX_IDLE,
// so a transfer always starts a frame and tx drops at that same edge.
// The FSM state register is named state (type tx_state_t) for observation.
module uart_tx_8n1
  import bomber_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  assign ready = (state == TX_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (valid) begin
            shreg    <= data;
            tx       <= 1'b0;
            baud_cnt <= '0;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            state    <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= TX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              // shift first, so the next bit is shreg[1] of the current value
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= TX_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= TX_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/pad_cmd_tx.sv
// Keypad command transmitter: debounces five raw key levels, converts
// presses (and auto-repeat of held directions) into command bytes
// {101, action, right, left, down, up}, buffers them in a small FIFO and
// sends each as one 8N1 UART frame.
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   up, down, left, right, action    raw key levels, active-high, clk-synchronous
//   tx                               UART line, idle high
//   busy                             frame on the line or FIFO non-empty
//   overflow                         one-cycle pulse when an event is dropped
module pad_cmd_tx
  import bomber_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 5208,
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_CYCLES = 10000000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  input  logic action,
  output logic tx,
  output logic busy,
  output logic overflow
);

  localparam int               DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam int               REP_W    = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  localparam int               PTR_W    = $clog2(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] stable_q;
  logic [DEB_W-1:0]    deb_cnt [NUM_KEYS];

  always_comb begin
    raw         = '0;
    raw[UP]     = up;
    raw[DOWN]   = down;
    raw[LEFT]   = left;
    raw[RIGHT]  = right;
    raw[ACTION] = action;
  end

  // Debounce: stable follows raw only after DEB_CYCLES consecutive cycles
  // of disagreement; any agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable   <= '0;
      stable_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) deb_cnt[k] <= '0;
    end else begin
      stable_q <= stable;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (raw[k] == stable[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_LAST) begin
          stable[k]  <= raw[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Event generation: press bytes carry only the keys that rose this cycle;
  // repeat bytes carry the held directions and never the action key.
  logic [NUM_KEYS-1:0] rise;
  logic                press;
  logic                dir_held;
  logic                rep_expire;
  logic                ev_valid;
  cmd_byte_t           ev_byte;
  logic [REP_W-1:0]    rep_cnt;

  assign rise       = stable & ~stable_q;
  assign press      = |rise;
  assign dir_held   = |stable[RIGHT:UP];
  assign rep_expire = dir_held && (rep_cnt == REP_LAST);
  assign ev_valid   = press || rep_expire;

  always_comb begin
    ev_byte = make_cmd(5'b0);
    if (press) ev_byte = make_cmd(rise);
    else       ev_byte = make_cmd({1'b0, stable[RIGHT:UP]});
  end

  // A press wins over a simultaneous expiry and restarts the period.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rep_cnt <= '0;
    end else if (press || !dir_held || rep_expire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           tx_ready;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = !empty && tx_ready;
  // A full FIFO still takes the byte when a slot frees in the same cycle.
  assign push  = ev_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= ev_byte;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      overflow <= ev_valid && !push;
    end
  end

  // Both terms come straight from flops: FIFO pointers and FSM state.
  assign busy = !empty || !tx_ready;

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .resetn(resetn),
    .data  (mem[rd_ptr[PTR_W-1:0]]),
    .valid (!empty),
    .ready (tx_ready),
    .tx    (tx)
  );

endmodule

// File: tb/tb_pad_cmd_tx.sv
// Directed bench for pad_cmd_tx with small timing parameters.
// Inputs change 1 time unit after the rising edge; direct output checks are
// taken at the same point. A line monitor decodes frames at falling edges.
module tb_pad_cmd_tx;

  localparam int CPB = 4;
  localparam int DEB = 8;
  localparam int REP = 64;
  localparam int FD  = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic up     = 1'b0;
  logic down   = 1'b0;
  logic left   = 1'b0;
  logic right  = 1'b0;
  logic action = 1'b0;
  logic tx;
  logic busy;
  logic overflow;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int ferr    = 0;
  int ovf_cnt = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pad_cmd_tx #(
    .CLKS_PER_BIT (CPB),
    .DEB_CYCLES   (DEB),
    .REPEAT_CYCLES(REP),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .up      (up),
    .down    (down),
    .left    (left),
    .right   (right),
    .action  (action),
    .tx      (tx),
    .busy    (busy),
    .overflow(overflow)
  );

  // Line monitor: decodes frames into rx_q with the cycle of the start bit
  // in rx_t; a reset during a frame abandons it.
  initial begin : rx_mon
    logic [7:0] b;
    bit         ab;
    int         t0;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && tx === 1'b0) begin
        t0 = cyc;
        ab = 1'b0;
        b  = '0;
        for (int k = 0; k < 38 && !ab; k++) begin
          @(negedge clk);
          if (resetn !== 1'b1) ab = 1'b1;
          else if (k == 1 && tx !== 1'b0) ferr++;
          else if (k >= 5 && k <= 33 && ((k - 5) % 4) == 0) b[(k - 5) / 4] = tx;
          else if (k == 37 && tx !== 1'b1) ferr++;
        end
        if (!ab) begin
          rx_q.push_back(b);
          rx_t.push_back(t0);
        end
      end
    end
  end

  always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    tick(3);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    resetn = 1'b1;
    tick(2);
  endtask

  task automatic test_bounce();
    int bad;
    bad = 0;
    clear_rx();
    for (int i = 0; i < 30; i++) begin
      up = ((i / 3) % 2 == 0);
      tick(1);
      if (tx !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0) bad++;
    end
    up = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (tx !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bounce_quiet: %0d active cycles, want 0", bad); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL bounce_frames: got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_clean_press();
    logic [9:0] fr;
    logic [7:0] got;
    fr = {1'b1, 8'hA4, 1'b0};
    clear_rx();
    left = 1'b1;
    tick(8);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL press_busy_e8: got %b want 0", busy); end
    tick(1);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL press_tx_e9: got %b want 1", tx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL press_busy_e9: got %b want 1", busy); end
    for (int c = 10; c < 50; c++) begin
      tick(1);
      if (c == 12) left = 1'b0;
      checks++;
      if (tx !== fr[(c - 10) / 4]) begin
        errors++;
        $display("FAIL press_frame cycle %0d: got %b want %b", c, tx, fr[(c - 10) / 4]);
      end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL press_busy_e49: got %b want 1", busy); end
    tick(1);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL press_tx_e50: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL press_busy_e50: got %b want 0", busy); end
    tick(60);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL press_count: got %0d want 1", rx_q.size()); end
    checks++; if (got !== 8'hA4) begin errors++; $display("FAIL press_byte: got %h want a4", got); end
  endtask

  task automatic test_merge();
    logic [7:0] got;
    clear_rx();
    right  = 1'b1;
    action = 1'b1;
    tick(20);
    right  = 1'b0;
    action = 1'b0;
    tick(150);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL merge_count: got %0d want 1", rx_q.size()); end
    checks++; if (got !== 8'hB8) begin errors++; $display("FAIL merge_byte: got %h want b8", got); end
  endtask

  task automatic test_auto_repeat();
    logic [7:0] got;
    int dt;
    clear_rx();
    exp_q.push_back(8'hB2);
    repeat (4) exp_q.push_back(8'hA2);
    down   = 1'b1;
    action = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick(1);
      if (i == 100) action = 1'b0;
    end
    down = 1'b0;
    tick(100);
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL repeat_count: got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL repeat_byte %0d: got %h want %h", i, got, exp_q[i]); end
    end
    for (int i = 1; i < exp_q.size(); i++) begin
      dt = (i < rx_t.size()) ? rx_t[i] - rx_t[i - 1] : -1;
      checks++; if (dt != REP) begin errors++; $display("FAIL repeat_spacing %0d: got %0d want %0d", i, dt, REP); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    int ovf0;
    int dt;
    clear_rx();
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA4);
    exp_q.push_back(8'hA8);
    exp_q.push_back(8'hB0);
    ovf0 = ovf_cnt;
    for (int i = 0; i < 40; i++) begin
      case (i)
        0:  up = 1'b1;
        1:  down = 1'b1;
        2:  left = 1'b1;
        3:  right = 1'b1;
        4:  action = 1'b1;
        8:  up = 1'b0;
        16: up = 1'b1;
        26: begin up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; action = 1'b0; end
        default: ;
      endcase
      if (i == 24 || i == 26) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_quiet e%0d: got %b want 0", i, overflow); end
      end
      if (i == 25) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse e25: got %b want 1", overflow); end
      end
      tick(1);
    end
    tick(250);
    checks++; if (ovf_cnt - ovf0 != 1) begin errors++; $display("FAIL ovf_count: got %0d want 1", ovf_cnt - ovf0); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_frames: got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL ovf_byte %0d: got %h want %h", i, got, exp_q[i]); end
    end
    for (int i = 1; i < exp_q.size(); i++) begin
      dt = (i < rx_t.size()) ? rx_t[i] - rx_t[i - 1] : -1;
      checks++; if (dt != 10 * CPB + 1) begin errors++; $display("FAIL back_to_back %0d: got %0d want %0d", i, dt, 10 * CPB + 1); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    lows = 0;
    clear_rx();
    up = 1'b1;
    tick(20);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    resetn = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow: got %b want 0", overflow); end
    up = 1'b0;
    tick(3);
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (tx !== 1'b1) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL midrst_line: %0d low cycles, want 0", lows); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after: got %b want 0", busy); end
    checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL midrst_frames: got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_framing();
    checks++; if (ferr != 0) begin errors++; $display("FAIL framing: %0d bad start/stop bits, want 0", ferr); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_merge();
    test_auto_repeat();
    test_overflow();
    test_reset_mid_frame();
    test_framing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
